store_order_ctrl: RTL and testbench
===================================

# store_order_ctrl

Ordering and throttling controller between the load/store unit and the write-through data-cache write path. It limits in-flight stores to the configured maximum of outstanding stores. It holds loads that target non-idempotent regions until every earlier store is acknowledged. It also drains all outstanding stores on a fence request. It is purely sequencing logic: it gates request grants and tracks completions, and carries no data.

## Interface
- AddrWidth, 64, width of load/store addresses
- MaxOutstanding, 7, maximum stores granted but not yet acknowledged
- NrNiRules, 2, number of non-idempotent region rules
- NiBase, all zero (NrNiRules*AddrWidth bits, packed), base address per rule; rule i occupies bits [i*AddrWidth +: AddrWidth]
- NiLength, all zero (same packing as NiBase), length per rule; length 0 disables the rule
- CntWidth, $clog2(MaxOutstanding+1), derived, not overridable
- clk_i  in  1  clock; all state updates on the rising edge
- rst_ni  in  1  asynchronous active-low reset
- st_req_i  in  1  store request from the LSU
- st_addr_i  in  AddrWidth  store address; informational only
- st_gnt_o  out  1  store accepted this cycle
- st_ack_i  in  1  one store completion (write response) this cycle
- ld_req_i  in  1  load request from the LSU
- ld_addr_i  in  AddrWidth  load address, checked against the NI rules
- ld_gnt_o  out  1  load accepted this cycle
- fence_i  in  1  single-cycle request to drain all stores
- fence_done_o  out  1  single-cycle pulse when the drain completes
- outstanding_o  out  CntWidth  current outstanding-store count
- no_st_pending_o  out  1  asserted when outstanding_o == 0
- cnt_err_o  out  1  sticky flag: an ack arrived while the count was 0

## Operation
- NI match: ld_addr_i is non-idempotent if, for any rule i with NiLength[i] != 0, NiBase[i] <= addr < NiBase[i] + NiLength[i]. The check is unsigned and full AddrWidth. Sum overflow wraps and is not checked.
- State register has three states: IDLE, LD_WAIT, FENCE_WAIT.
- IDLE:
  - st_gnt_o = st_req_i & (cnt < MaxOutstanding).
  - For a normal load, ld_gnt_o = ld_req_i.
  - For an NI load, ld_gnt_o = ld_req_i & (cnt == 0) & ~st_req_i. The LSU presents stores older than loads, so a simultaneous store is served first.
  - An NI load that is not granted moves the state to LD_WAIT.
  - fence_i moves the state to FENCE_WAIT and suppresses all grants in that cycle. fence_i has priority over a same-cycle LD_WAIT entry.
- LD_WAIT:
  - st_gnt_o = 0.
  - ld_gnt_o = ld_req_i & (cnt == 0); the state returns to IDLE on that grant.
  - If ld_req_i drops, return to IDLE; no grant is issued.
  - fence_i is ignored in this state. The LSU never fences with a load pending.
- FENCE_WAIT:
  - No grants are issued.
  - When cnt == 0, pulse fence_done_o for one cycle and return to IDLE.
- Counter: cnt_next = cnt + st_gnt_o - (st_ack_i & (cnt != 0)).
  - A grant and an ack in the same cycle leave the count unchanged.
  - An ack while cnt == 0 leaves the count at 0 and sets cnt_err_o; the flag clears only on reset.
- Grants depend only on registered state and count plus the current-cycle requests. An ack does not free a slot until the following cycle.

## Timing
- Reset values: state = IDLE, cnt = 0, outstanding_o = 0, no_st_pending_o = 1, fence_done_o = 0, cnt_err_o = 0.
- Grants are combinational with zero cycles of latency; all state updates land on the next rising edge.
- The LSU holds a request asserted until it is granted; address is stable while the request is high.
- Stores at the cap: if cnt == MaxOutstanding, a store is granted at the earliest in the cycle after the first ack.
- NI load wait: an NI load waiting on N outstanding stores is granted in the cycle after the Nth ack.
- Fence latency:
  - With cnt == 0 at fence_i, fence_done_o pulses in the next cycle.
  - Otherwise it pulses in the cycle after the ack that brings cnt to 0.
- Asynchronous reset mid-operation immediately forces all outputs to their reset values. Outstanding acks that arrive after reset are treated as underflow and set cnt_err_o; the system must reset the bus alongside this block.

## Test plan
- Store cap: 8 back-to-back store requests with no ack → 7 grants, outstanding_o = 7, 8th held. One ack → 8th granted the following cycle, count stays at 7.
- Simultaneous grant and ack: at cnt = 3, a store grant and an ack in the same cycle → outstanding_o remains 3.
- NI load: rule 0 = base 0x1000_0000, length 0x1000; load to 0x1000_0010 with cnt = 3 → LD_WAIT, no grant. After 3 acks → ld_gnt_o in the next cycle, state back to IDLE. A load to 0x8000_0000 in IDLE → granted the same cycle.
- Fence: with cnt = 2, fence_i, then acks at cycles +3 and +5 → no grants during the wait, fence_done_o pulses at +6 only. Fence with cnt = 0 → fence_done_o pulses at +1.
- Underflow: ack with cnt = 0 → cnt_err_o = 1 and stays set, outstanding_o = 0. Reset clears it.
- Reset mid-operation: assert rst_ni low with cnt = 5 in LD_WAIT → outputs immediately at reset values. After release, a store is granted in the first request cycle.

Source files
------------

// File: rtl/store_order_ctrl.sv
// Store ordering/throttling controller: caps outstanding stores, holds loads to
// non-idempotent regions behind earlier stores, and drains stores on fence.

module store_order_ni_match #(
  parameter int unsigned AddrWidth = 64
) (
  input  logic [AddrWidth-1:0] base_i,
  input  logic [AddrWidth-1:0] len_i,
  input  logic [AddrWidth-1:0] addr_i,
  output logic                 hit_o
);
  logic [AddrWidth-1:0] limit;

  // Upper bound wraps on overflow; a wrapped window is simply whatever the
  // unsigned compare yields.
  assign limit = base_i + len_i;
  assign hit_o = (len_i != '0) && (addr_i >= base_i) && (addr_i < limit);
endmodule

module store_order_ctrl #(
  parameter int unsigned AddrWidth      = 64,
  parameter int unsigned MaxOutstanding = 7,
  parameter int unsigned NrNiRules      = 2,
  parameter logic [NrNiRules*AddrWidth-1:0] NiBase   = '0,
  parameter logic [NrNiRules*AddrWidth-1:0] NiLength = '0,
  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 st_req_i,
  input  logic [AddrWidth-1:0] st_addr_i,
  output logic                 st_gnt_o,
  input  logic                 st_ack_i,
  input  logic                 ld_req_i,
  input  logic [AddrWidth-1:0] ld_addr_i,
  output logic                 ld_gnt_o,
  input  logic                 fence_i,
  output logic                 fence_done_o,
  output logic [CntWidth-1:0]  outstanding_o,
  output logic                 no_st_pending_o,
  output logic                 cnt_err_o
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LD_WAIT    = 2'd1,
    FENCE_WAIT = 2'd2
  } state_e;

  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOutstanding);

  state_e              state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                cnt_err_q, cnt_err_d;

  logic [NrNiRules-1:0] ni_hit;
  logic                 ld_is_ni;
  logic                 cnt_zero;
  logic                 cnt_room;
  logic                 ack_dec;
  logic                 st_gnt, ld_gnt, fence_done;
  logic                 unused_st_addr;

  // The store address carries no ordering information here.
  assign unused_st_addr = ^st_addr_i;

  for (genvar i = 0; i < NrNiRules; i++) begin : g_ni
    store_order_ni_match #(
      .AddrWidth(AddrWidth)
    ) u_match (
      .base_i (NiBase[i*AddrWidth +: AddrWidth]),
      .len_i  (NiLength[i*AddrWidth +: AddrWidth]),
      .addr_i (ld_addr_i),
      .hit_o  (ni_hit[i])
    );
  end

  assign ld_is_ni = |ni_hit;
  assign cnt_zero = (cnt_q == '0);
  assign cnt_room = (cnt_q < CntMax);
  assign ack_dec  = st_ack_i & ~cnt_zero;

  always_comb begin
    state_d    = state_q;
    st_gnt     = 1'b0;
    ld_gnt     = 1'b0;
    fence_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fence_i) begin
          state_d = FENCE_WAIT;
        end else begin
          st_gnt = st_req_i & cnt_room;
          // A same-cycle store is older than the load, so it goes first.
          if (ld_is_ni) ld_gnt = ld_req_i & cnt_zero & ~st_req_i;
          else          ld_gnt = ld_req_i;
          if (ld_req_i && ld_is_ni && !ld_gnt) state_d = LD_WAIT;
        end
      end
      LD_WAIT: begin
        ld_gnt = ld_req_i & cnt_zero;
        if (!ld_req_i || ld_gnt) state_d = IDLE;
      end
      FENCE_WAIT: begin
        if (cnt_zero) begin
          fence_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    cnt_err_d = cnt_err_q | (st_ack_i & cnt_zero);
    if (st_gnt && !ack_dec)      cnt_d = cnt_q + CntWidth'(1);
    else if (!st_gnt && ack_dec) cnt_d = cnt_q - CntWidth'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cnt_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cnt_err_q <= cnt_err_d;
    end
  end

  assign st_gnt_o        = st_gnt;
  assign ld_gnt_o        = ld_gnt;
  assign fence_done_o    = fence_done;
  assign outstanding_o   = cnt_q;
  assign no_st_pending_o = cnt_zero;
  assign cnt_err_o       = cnt_err_q;

endmodule

// File: tb/tb_store_order_ctrl.sv
// Scoreboarded bench for store_order_ctrl: directed scenarios then random LSU traffic
// against a transaction-level model of the ordering rules.

module tb_store_order_ctrl;
  localparam int AW   = 64;
  localparam int MAXO = 7;
  localparam logic [63:0] B0 = 64'h1000_0000, L0 = 64'h1000;
  localparam logic [63:0] B1 = 64'h4000_0000, L1 = 64'h10;

  logic clk = 1'b0, rst_ni = 1'b0;
  logic st_req_i = 0, st_ack_i = 0, ld_req_i = 0, fence_i = 0;
  logic [AW-1:0] st_addr_i = '0, ld_addr_i = '0;
  logic st_gnt_o, ld_gnt_o, fence_done_o, no_st_pending_o, cnt_err_o;
  logic [2:0] outstanding_o;

  always #5 clk = ~clk;

  store_order_ctrl #(
    .AddrWidth(AW), .MaxOutstanding(MAXO), .NrNiRules(2),
    .NiBase({B1, B0}), .NiLength({L1, L0})
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .st_req_i(st_req_i), .st_addr_i(st_addr_i), .st_gnt_o(st_gnt_o), .st_ack_i(st_ack_i),
    .ld_req_i(ld_req_i), .ld_addr_i(ld_addr_i), .ld_gnt_o(ld_gnt_o),
    .fence_i(fence_i), .fence_done_o(fence_done_o),
    .outstanding_o(outstanding_o), .no_st_pending_o(no_st_pending_o), .cnt_err_o(cnt_err_o)
  );

  typedef struct packed {
    logic sg, lg, fd, np, er;
    logic [2:0] oc;
  } exp_t;

  exp_t sbq[$];
  int n_tests = 0, n_fail = 0;

  // Model: number of stores in flight, plus whether a load or a fence is parked.
  int m_cnt;
  bit m_ld_parked, m_fencing, m_err;
  bit last_sg, last_lg;
  bit st_pend, ld_pend;
  logic [63:0] ld_a;

  function automatic bit is_ni(logic [63:0] a);
    logic [63:0] e0, e1;
    e0 = B0 + L0;
    e1 = B1 + L1;
    return (a >= B0 && a < e0) || (a >= B1 && a < e1);
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: one expected response per cycle, compared mid-cycle.
  initial forever begin
    @(negedge clk);
    if (rst_ni && sbq.size() > 0) begin
      exp_t e, a;
      e = sbq.pop_front();
      a = {st_gnt_o, ld_gnt_o, fence_done_o, no_st_pending_o, cnt_err_o, outstanding_o};
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL sb {sg,lg,fd,np,er,cnt} actual=%b expected=%b t=%0t", a, e, $time);
      end
    end
  end

  // Called at posedge+1; drives one cycle and returns at the next posedge+1.
  task automatic cycle(input bit st, input bit ld, input logic [63:0] a, input bit fn, input bit ack);
    bit sg, lg, fd, ni;
    st_req_i = st; ld_req_i = ld; ld_addr_i = a; fence_i = fn; st_ack_i = ack;
    st_addr_i = {$urandom, $urandom};
    ni = is_ni(a);
    sg = 0; lg = 0; fd = 0;
    if (m_fencing) fd = (m_cnt == 0);
    else if (m_ld_parked) lg = ld && (m_cnt == 0);
    else if (!fn) begin
      sg = st && (m_cnt < MAXO);
      lg = ld && (!ni || (m_cnt == 0 && !st));
    end
    sbq.push_back({sg, lg, fd, (m_cnt == 0), m_err, 3'(m_cnt)});
    last_sg = sg; last_lg = lg;
    @(posedge clk);
    if (m_fencing) begin
      if (m_cnt == 0) m_fencing = 0;
    end else if (m_ld_parked) begin
      if (!ld || lg) m_ld_parked = 0;
    end else if (fn) m_fencing = 1;
    else if (ld && ni && !lg) m_ld_parked = 1;
    if (ack && m_cnt == 0) m_err = 1;
    m_cnt = m_cnt + int'(sg) - int'(ack && m_cnt > 0);
    #1;
  endtask

  task automatic clear_inputs();
    st_req_i = 0; ld_req_i = 0; fence_i = 0; st_ack_i = 0;
  endtask

  task automatic model_reset();
    m_cnt = 0; m_ld_parked = 0; m_fencing = 0; m_err = 0;
    st_pend = 0; ld_pend = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_ni = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ni = 1;
    @(posedge clk); #1;
    sbq.delete();
    model_reset();
  endtask

  function automatic logic [63:0] pick_addr();
    case ($urandom_range(0, 5))
      0: return B0 + 64'($urandom_range(0, 32'hFFF));
      1: return B0 + L0;
      2: return B0 - 64'd1;
      3: return B1 + L1 - 64'd1;
      4: return B1 + L1;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    model_reset();
    do_reset();
    check("rst_cnt", outstanding_o, 0);
    check("rst_nopend", no_st_pending_o, 1);
    check("rst_fdone", fence_done_o, 0);
    check("rst_err", cnt_err_o, 0);

    // Store cap.
    repeat (8) cycle(1, 0, '0, 0, 0);
    check("cap_cnt", outstanding_o, 7);
    cycle(1, 0, '0, 0, 1);
    check("cap_after_ack", outstanding_o, 6);
    cycle(1, 0, '0, 0, 0);
    check("cap_refill", outstanding_o, 7);
    repeat (7) cycle(0, 0, '0, 0, 1);
    check("drain", outstanding_o, 0);

    // Grant and ack in the same cycle.
    repeat (3) cycle(1, 0, '0, 0, 0);
    cycle(1, 0, '0, 0, 1);
    check("gnt_ack_same", outstanding_o, 3);

    // NI load waits for all 3 stores.
    cycle(0, 1, 64'h1000_0010, 0, 0);
    repeat (3) cycle(0, 1, 64'h1000_0010, 0, 1);
    cycle(0, 1, 64'h1000_0010, 0, 0);
    cycle(0, 1, 64'h8000_0000, 0, 0);
    // NI load dropped while parked: state returns to IDLE, store then flows.
    cycle(1, 0, '0, 0, 0);
    cycle(0, 1, 64'h4000_0008, 0, 0);
    cycle(0, 0, '0, 0, 0);
    cycle(1, 0, '0, 0, 0);
    check("ni_drop", outstanding_o, 2);

    // Fence with two stores outstanding; store request held throughout.
    cycle(1, 0, '0, 1, 0);
    cycle(1, 0, '0, 0, 0);
    cycle(1, 0, '0, 0, 0);
    cycle(1, 0, '0, 0, 1);
    cycle(1, 0, '0, 0, 0);
    cycle(1, 0, '0, 0, 1);
    cycle(1, 0, '0, 0, 0);
    cycle(1, 0, '0, 0, 0);
    check("fence_resume", outstanding_o, 1);
    cycle(0, 0, '0, 0, 1);
    // Fence with nothing outstanding.
    cycle(0, 0, '0, 1, 0);
    cycle(0, 0, '0, 0, 0);
    cycle(0, 0, '0, 0, 0);

    // Underflow is sticky until reset.
    cycle(0, 0, '0, 0, 1);
    cycle(0, 0, '0, 0, 0);
    check("uflow_err", cnt_err_o, 1);
    check("uflow_cnt", outstanding_o, 0);
    do_reset();
    check("uflow_clr", cnt_err_o, 0);

    // Async reset mid-operation with a parked NI load.
    repeat (5) cycle(1, 0, '0, 0, 0);
    cycle(0, 1, 64'h1000_0000, 0, 0);
    cycle(0, 1, 64'h1000_0000, 0, 0);
    clear_inputs();
    #2 rst_ni = 0;
    #1;
    check("arst_cnt", outstanding_o, 0);
    check("arst_nopend", no_st_pending_o, 1);
    check("arst_err", cnt_err_o, 0);
    check("arst_fdone", fence_done_o, 0);
    check("arst_gnts", {st_gnt_o, ld_gnt_o}, 0);
    @(negedge clk);
    rst_ni = 1;
    @(posedge clk); #1;
    sbq.delete();
    model_reset();
    cycle(1, 0, '0, 0, 0);
    check("arst_store", outstanding_o, 1);
    cycle(0, 0, '0, 0, 1);

    // Random LSU traffic.
    for (int i = 0; i < 3000; i++) begin
      bit fn, ack;
      if (!st_pend && $urandom_range(0, 99) < 45) st_pend = 1;
      if (!ld_pend && $urandom_range(0, 99) < 30) begin
        ld_pend = 1;
        ld_a = pick_addr();
      end
      fn  = !ld_pend && !m_fencing && !m_ld_parked && ($urandom_range(0, 99) < 4);
      ack = (m_cnt > 0) && ($urandom_range(0, 99) < 35);
      cycle(st_pend, ld_pend, ld_a, fn, ack);
      if (last_sg) st_pend = 0;
      if (last_lg) ld_pend = 0;
    end

    clear_inputs();
    @(negedge clk); #1;
    check("sb_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
